// File: rtl/display_pkg.sv
// display_pkg: shared constants for the 7-segment display path
package display_pkg;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;
  localparam logic       ANODE_OFF  = 1'b1;
  localparam logic [3:0] BCD_MAX    = 4'd9;
endpackage

// File: rtl/segment_display.sv
// segment_display: BCD to active-low 7-segment decoder, DP (bit7) left off
// ports: num = BCD digit in; segment_code = active-low {dp,g,f,e,d,c,b,a}, blank for non-BCD
module segment_display
  import display_pkg::*;
(
  input  logic [3:0] num,
  output logic [7:0] segment_code
);
  always_comb begin
    case (num)
      4'd0:    segment_code = 8'hC0;
      4'd1:    segment_code = 8'hF9;
      4'd2:    segment_code = 8'hA4;
      4'd3:    segment_code = 8'hB0;
      4'd4:    segment_code = 8'h99;
      4'd5:    segment_code = 8'h92;
      4'd6:    segment_code = 8'h82;
      4'd7:    segment_code = 8'hF8;
      4'd8:    segment_code = 8'h80;
      4'd9:    segment_code = 8'h90;
      default: segment_code = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes BCD digits onto one active-low 7-seg bus with common anodes
// ports: clk, reset (sync, active-high); digits_bcd digit i at [4i+3:4i]; dp_mask/blink_mask per digit;
//        blank_lz suppresses leading zeros; seg_out active-low, bit7 = DP; an_out active-low anodes
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_SCANS  = 125
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out
);
  localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  logic [SW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           scan_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] snapshot;
  logic                    slot_end, scan_end, scan_wrap, gap, lz, lz_run;
  logic [3:0]              digit;
  logic [7:0]              code;
  assign slot_end  = slot_cnt == SW'(REFRESH_DIV - 1);
  assign scan_end  = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign scan_wrap = scan_cnt == CW'(BLINK_SCANS - 1);
  assign gap       = slot_cnt < SW'(BLANK_CYCLES);
  assign digit     = snapshot[4*idx +: 4];
  segment_display u_dec (.num(digit), .segment_code(code));
  // lz_run accumulates "this digit and all above are zero" walking down from the top
  always_comb begin
    lz_run = 1'b1;
    lz     = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && snapshot[4*i +: 4] == 4'd0;
      lz     = (blank_lz && idx == IW'(i)) ? lz_run : lz;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      idx         <= '0;
      scan_cnt    <= '0;
      blink_phase <= 1'b0;
      snapshot    <= '0;
      seg_out     <= SEG_BLANK;
      an_out      <= {NUM_DIGITS{ANODE_OFF}};
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) idx <= scan_end ? '0 : idx + 1'b1;
      if (scan_end) begin
        snapshot    <= digits_bcd;
        scan_cnt    <= scan_wrap ? '0 : scan_cnt + 1'b1;
        blink_phase <= blink_phase ^ scan_wrap;
      end
      seg_out <= (gap || digit > BCD_MAX || lz || (blink_mask[idx] && blink_phase)) ? SEG_BLANK
               : {code[SEG_DP_BIT] & ~dp_mask[idx], code[SEG_DP_BIT-1:0]};
      an_out  <= gap ? {NUM_DIGITS{ANODE_OFF}} : ~(NUM_DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed checks of scan timing, snapshot, blanking, blink and DP
module tb_display_scan_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_mask, blink_mask;
  logic        blank_lz;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  int          errors = 0;
  int          checks = 0;
  int          k = 0;
  display_scan_controller #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_SCANS(2)
  ) dut (
    .clk(clk), .reset(reset), .digits_bcd(digits_bcd), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .seg_out(seg_out), .an_out(an_out)
  );
  always #5 clk = ~clk;
  // k counts rising edges since reset release; checks happen on the following falling edge,
  // where the output shows slot (k-1)%8 of digit ((k-1)/8)%4
  task automatic go(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] se, input logic [3:0] ae);
    checks++;
    assert (seg_out === se) else begin
      errors++;
      $error("FAIL %s seg_out=%h expected %h (k=%0d)", tag, seg_out, se, k);
    end
    checks++;
    assert (an_out === ae) else begin
      errors++;
      $error("FAIL %s an_out=%b expected %b (k=%0d)", tag, an_out, ae, k);
    end
  endtask
  initial begin
    reset = 1'b1; digits_bcd = 16'h1234; dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", 8'hFF, 4'b1111);
    reset = 1'b0;
    k = 0;
    go(1);  chk("rel_k1_gap", 8'hFF, 4'b1111);
    go(2);  chk("rel_k2_gap", 8'hFF, 4'b1111);
    go(3);  chk("rel_first_anode_zero_snap", 8'hC0, 4'b1110);
    go(9);  chk("slot1_gap", 8'hFF, 4'b1111);
    go(11); chk("slot1_zero_snap", 8'hC0, 4'b1101);
    go(35); chk("s1_d0_4", 8'h99, 4'b1110);
    go(41); chk("s1_d1_gap0", 8'hFF, 4'b1111);
    go(42); chk("s1_d1_gap1", 8'hFF, 4'b1111);
    go(43); chk("s1_d1_3", 8'hB0, 4'b1101);
    go(48); chk("s1_d1_last", 8'hB0, 4'b1101);
    go(51); chk("s1_d2_2", 8'hA4, 4'b1011);
    digits_bcd = 16'h5678;
    go(55); chk("s1_d2_held", 8'hA4, 4'b1011);
    go(59); chk("s1_d3_held", 8'hF9, 4'b0111);
    go(67); chk("s2_d0_8", 8'h80, 4'b1110);
    go(75); chk("s2_d1_7", 8'hF8, 4'b1101);
    go(83); chk("s2_d2_6", 8'h82, 4'b1011);
    go(91); chk("s2_d3_5", 8'h92, 4'b0111);
    digits_bcd = 16'h0007; blank_lz = 1'b1;
    go(99);  chk("lz7_d0", 8'hF8, 4'b1110);
    go(107); chk("lz7_d1", 8'hFF, 4'b1101);
    go(115); chk("lz7_d2", 8'hFF, 4'b1011);
    go(123); chk("lz7_d3", 8'hFF, 4'b0111);
    digits_bcd = 16'h0000;
    go(131); chk("lz0_d0", 8'hC0, 4'b1110);
    go(139); chk("lz0_d1", 8'hFF, 4'b1101);
    digits_bcd = 16'h1234; blank_lz = 1'b0; blink_mask = 4'b0001; dp_mask = 4'b0100;
    go(163); chk("blink_s5_on", 8'h99, 4'b1110);
    go(179); chk("dp_s5_d2", 8'h24, 4'b1011);
    go(195); chk("blink_s6_off", 8'hFF, 4'b1110);
    go(211); chk("dp_s6_d2", 8'h24, 4'b1011);
    go(227); chk("blink_s7_off", 8'hFF, 4'b1110);
    go(259); chk("blink_s8_on", 8'h99, 4'b1110);
    digits_bcd = 16'h12C4;
    go(299); chk("bad_digit", 8'hFF, 4'b1101);
    go(300); chk("bad_digit_mid", 8'hFF, 4'b1101);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_slot", 8'hFF, 4'b1111);
    reset = 1'b0;
    k = 0;
    go(2); chk("rerel_gap", 8'hFF, 4'b1111);
    go(3); chk("rerel_idx0_snap0", 8'hC0, 4'b1110);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
